// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the per-axis phase type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_pkg;

    // 640x480 @ 60 Hz industry timing, in pixels (h) and lines (v)
    localparam int DEF_ACTIVE_COLS = 640;
    localparam int DEF_H_FRONT     = 16;
    localparam int DEF_H_SYNC      = 96;
    localparam int DEF_H_BACK      = 48;
    localparam int DEF_ACTIVE_ROWS = 480;
    localparam int DEF_V_FRONT     = 10;
    localparam int DEF_V_SYNC      = 2;
    localparam int DEF_V_BACK      = 33;
    localparam int DEF_CLK_DIV     = 2;

    // Phases each axis walks through, in order, once per line/frame
    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } phase_t;

    // Successor of a phase in the ACTIVE -> FRONT -> SYNC -> BACK ring
    function automatic phase_t next_phase(input phase_t p);
        phase_t n;
        case (p)
            ACTIVE:  n = FRONT;
            FRONT:   n = SYNC;
            SYNC:    n = BACK;
            default: n = ACTIVE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sync_phase_counter.sv
// One timing axis: absolute position plus ACTIVE/FRONT/SYNC/BACK phase tracking.
// Latency: count/phase update on the clk after advance; wrap is combinational from state.
// Backpressure: none; steps exactly once per clk with advance high.
module sync_phase_counter
    import vga_pkg::*;
#(
    parameter int LEN_ACTIVE = DEF_ACTIVE_COLS,
    parameter int LEN_FRONT  = DEF_H_FRONT,
    parameter int LEN_SYNC   = DEF_H_SYNC,
    parameter int LEN_BACK   = DEF_H_BACK,
    parameter int CW         = $clog2(LEN_ACTIVE + LEN_FRONT + LEN_SYNC + LEN_BACK)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          advance,
    output logic [CW-1:0] count,
    output phase_t        phase,
    output logic          wrap
);

    phase_t        phase_q, phase_d;
    logic [CW-1:0] local_q, local_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] phase_last;
    logic          at_last;

    // Last phase-local index of whichever phase is currently running
    always_comb begin
        phase_last = '0;
        case (phase_q)
            ACTIVE:  phase_last = CW'(LEN_ACTIVE - 1);
            FRONT:   phase_last = CW'(LEN_FRONT - 1);
            SYNC:    phase_last = CW'(LEN_SYNC - 1);
            BACK:    phase_last = CW'(LEN_BACK - 1);
            default: phase_last = '0;
        endcase
    end

    assign at_last = (local_q == phase_last);
    // Final position of the line/frame is the last slot of BACK
    assign wrap    = (phase_q == BACK) && at_last;

    // Next-state: step phase-local and absolute counters together on advance
    always_comb begin
        phase_d = phase_q;
        local_d = local_q;
        count_d = count_q;
        if (advance) begin
            if (at_last) begin
                local_d = '0;
                phase_d = next_phase(phase_q);
            end else begin
                local_d = local_q + 1'b1;
            end
            count_d = wrap ? '0 : count_q + 1'b1;
        end
    end

    // State register; reset parks the axis at position 0 of ACTIVE
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= ACTIVE;
            local_q <= '0;
            count_q <= '0;
        end else begin
            phase_q <= phase_d;
            local_q <= local_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign phase = phase_q;

endmodule

// File: rtl/vga_timing.sv
// VGA raster generator: pixel-rate divider, h/v phase counters, registered sync/visible outputs.
// Latency: outputs reflect the counter position they were loaded from, one clk after the pix_tick edge.
// Backpressure: none; free-running, outputs hold between pix_ticks.
module vga_timing
    import vga_pkg::*;
#(
    parameter int ACTIVE_COLS = DEF_ACTIVE_COLS,
    parameter int H_FRONT     = DEF_H_FRONT,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BACK      = DEF_H_BACK,
    parameter int ACTIVE_ROWS = DEF_ACTIVE_ROWS,
    parameter int V_FRONT     = DEF_V_FRONT,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BACK      = DEF_V_BACK,
    parameter int CLK_DIV     = DEF_CLK_DIV
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic                           pix_tick,
    output logic                           hsync,
    output logic                           vsync,
    output logic                           active,
    output logic [$clog2(ACTIVE_COLS)-1:0] col,
    output logic [$clog2(ACTIVE_ROWS)-1:0] row,
    output logic                           frame_start
);

    localparam int H_TOTAL = ACTIVE_COLS + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = ACTIVE_ROWS + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int COL_W   = $clog2(ACTIVE_COLS);
    localparam int ROW_W   = $clog2(ACTIVE_ROWS);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q;
    logic             tick;
    logic [HW-1:0]    h_count;
    logic [VW-1:0]    v_count;
    phase_t           h_phase, v_phase;
    logic             h_wrap, v_wrap;
    logic             v_advance;
    logic             at_origin;
    logic             visible;

    // Divider position 0 is the pixel slot; reset leaves it there so the
    // first clk after release already carries a pix_tick
    assign tick = (div_q == '0);

    // Pixel-rate divider cycling 0..CLK_DIV-1
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else if (div_q == DIV_W'(CLK_DIV - 1)) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign v_advance = tick & h_wrap;

    sync_phase_counter #(
        .LEN_ACTIVE (ACTIVE_COLS),
        .LEN_FRONT  (H_FRONT),
        .LEN_SYNC   (H_SYNC),
        .LEN_BACK   (H_BACK),
        .CW         (HW)
    ) u_h_axis (
        .clk     (clk),
        .rst     (rst),
        .advance (tick),
        .count   (h_count),
        .phase   (h_phase),
        .wrap    (h_wrap)
    );

    sync_phase_counter #(
        .LEN_ACTIVE (ACTIVE_ROWS),
        .LEN_FRONT  (V_FRONT),
        .LEN_SYNC   (V_SYNC),
        .LEN_BACK   (V_BACK),
        .CW         (VW)
    ) u_v_axis (
        .clk     (clk),
        .rst     (rst),
        .advance (v_advance),
        .count   (v_count),
        .phase   (v_phase),
        .wrap    (v_wrap)
    );

    // Tracks "counters sit at (0,0)" so frame_start needs no wide compare
    always_ff @(posedge clk) begin
        if (rst) begin
            at_origin <= 1'b1;
        end else if (tick) begin
            at_origin <= h_wrap & v_wrap;
        end
    end

    assign visible = (h_phase == ACTIVE) && (v_phase == ACTIVE);

    // Output register: strobes every clk, level outputs load only on pix_tick
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_tick    <= 1'b0;
            frame_start <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            active      <= 1'b0;
            col         <= '0;
            row         <= '0;
        end else begin
            pix_tick    <= tick;
            frame_start <= tick & at_origin;
            if (tick) begin
                hsync  <= (h_phase != SYNC);
                vsync  <= (v_phase != SYNC);
                active <= visible;
                col    <= visible ? COL_W'(h_count) : '0;
                row    <= visible ? ROW_W'(v_count) : '0;
            end
        end
    end

endmodule
